// File: rtl/motor_pkg.sv
// Types and constants shared by the motor speed path (blip conditioner and RPM calculator).
package motor_pkg;

    localparam int unsigned CLK_HZ   = 32'd50_000_000;
    localparam int unsigned PERIOD_W = 32'd32;

    typedef enum logic [0:0] {
        STALLED = 1'b0,
        RUN     = 1'b1
    } cond_state_t;

    // Saturating increment so a stopped motor never wraps back to a small period.
    function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
        logic [PERIOD_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + PERIOD_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/blip_conditioner_sync_filter.sv
// Two-flop synchroniser on the raw hall input followed by a consecutive-sample glitch filter.
module sync_filter #(
    parameter int unsigned FILTER_CYCLES = 64
) (
    input  logic clk50M,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam logic [16:0] FILT_LIM = 17'(FILTER_CYCLES);

    logic        sync1_q, sync1_d;
    logic        hall_s_q, hall_s_d;
    logic [15:0] cnt_q, cnt_d;
    logic        dout_q, dout_d;
    logic [16:0] cnt_inc_s;

    // Next-state: count consecutive disagreeing samples, toggle output when the run is long enough.
    always_comb begin
        sync1_d   = din;
        hall_s_d  = sync1_q;
        cnt_inc_s = {1'b0, cnt_q} + 17'd1;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        if (hall_s_q == dout_q) begin
            cnt_d = 16'd0;
        end else if (cnt_inc_s == FILT_LIM) begin
            cnt_d  = 16'd0;
            dout_d = ~dout_q;
        end else begin
            cnt_d = cnt_inc_s[15:0];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk50M) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            hall_s_q <= 1'b0;
            cnt_q    <= 16'd0;
            dout_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            hall_s_q <= hall_s_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/blip_conditioner.sv
// Hall input conditioner: filtered blips, rising-edge strobe, edge-to-edge period and stall flag.
module blip_conditioner
    import motor_pkg::*;
#(
    parameter int unsigned          FILTER_CYCLES = 64,
    parameter logic [PERIOD_W-1:0]  STALL_CYCLES  = 32'd25_000_000
) (
    input  logic                clk50M,
    input  logic                reset_n,
    input  logic                hall_raw,
    output logic                blips,
    output logic                edge_pulse,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stalled
);

    logic                blips_s;
    logic                rise_s;
    logic                blips_prev_q, blips_prev_d;
    logic                edge_pulse_q, edge_pulse_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_valid_q, period_valid_d;
    logic                stalled_q, stalled_d;
    cond_state_t         state_q, state_d;

    sync_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_sync_filter (
        .clk50M (clk50M),
        .reset_n(reset_n),
        .din    (hall_raw),
        .dout   (blips_s)
    );

    // Next-state: everything keyed off the rise so strobe, period and stall flag land together.
    always_comb begin
        rise_s         = blips_s & ~blips_prev_q;
        blips_prev_d   = blips_s;
        edge_pulse_d   = rise_s;
        period_d       = period_q;
        period_valid_d = 1'b0;
        state_d        = state_q;
        stalled_d      = stalled_q;
        if (rise_s) begin
            cnt_d = PERIOD_W'(1);
        end else begin
            cnt_d = sat_inc(cnt_q);
        end
        case (state_q)
            STALLED: begin
                if (rise_s) begin
                    state_d   = RUN;
                    stalled_d = 1'b0;
                end else begin
                    stalled_d = 1'b1;
                end
            end
            RUN: begin
                // An edge arriving on the timeout cycle still counts as a valid period.
                if (rise_s) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    stalled_d      = 1'b0;
                end else if (cnt_q == STALL_CYCLES) begin
                    state_d   = STALLED;
                    stalled_d = 1'b1;
                end else begin
                    stalled_d = 1'b0;
                end
            end
            default: begin
                state_d   = STALLED;
                stalled_d = 1'b1;
            end
        endcase
    end

    // Registers for edge detection, period counter and FSM with synchronous active-low reset.
    always_ff @(posedge clk50M) begin
        if (!reset_n) begin
            blips_prev_q   <= 1'b0;
            edge_pulse_q   <= 1'b0;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            state_q        <= STALLED;
            stalled_q      <= 1'b1;
        end else begin
            blips_prev_q   <= blips_prev_d;
            edge_pulse_q   <= edge_pulse_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            state_q        <= state_d;
            stalled_q      <= stalled_d;
        end
    end

    assign blips        = blips_s;
    assign edge_pulse   = edge_pulse_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign stalled      = stalled_q;

endmodule
